// File: rtl/regfile_pkg.sv
// regfile_pkg: definitions shared by the multi-port register file slice.
//   - State encoding of the clear sequencer (CLEAR sweeps the array, IDLE serves traffic)
//   - Default parameter values of regfile_mp
package regfile_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_ADDR_W   = 5;
    localparam int unsigned DEF_ZERO_REG = 1;
    localparam int unsigned DEF_BYPASS   = 1;
    localparam int unsigned DEF_TAP0_IDX = 2;
    localparam int unsigned DEF_TAP1_IDX = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: clear sequencer of the register file.
// It sweeps every entry to zero after reset or on a clear request.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset; holds the sequencer in CLEAR at entry 0
//   clearReq in   one-cycle request that starts a new sweep (honoured only in IDLE)
//   ready    out  high in IDLE
//   clrEn    out  high in CLEAR; zero is written to entry clrAddr on the next edge
//   clrAddr  out  sweep index
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clearReq,
    output logic              ready,
    output logic              clrEn,
    output logic [ADDR_W-1:0] clrAddr
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clrCnt_q, clrCnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= CLEAR;
            clrCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            clrCnt_q <= clrCnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        clrCnt_d = clrCnt_q;
        ready    = 1'b0;
        clrEn    = 1'b0;
        case (state_q)
            CLEAR: begin
                // clearReq is ignored here, so a sweep is never restarted.
                clrEn    = 1'b1;
                clrCnt_d = clrCnt_q + ADDR_W'(1);
                if (clrCnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                ready = 1'b1;
                if (clearReq) begin
                    state_d  = CLEAR;
                    clrCnt_d = '0;
                end
            end
            default: begin
                state_d  = CLEAR;
                clrCnt_d = '0;
            end
        endcase
    end

    assign clrAddr = clrCnt_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: register file with two combinational read ports, one write port,
// two fixed debug taps, an optional hard-wired zero entry and optional write bypass.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (starts a clear sweep)
//   readReg1/readReg2   read indices       -> reg1/reg2 read data (zero while not ready)
//   writeReg, Din, we   write index, data, enable (accepted only when ready)
//   clearReq            one-cycle pulse requesting a full clear sweep
//   v0, a0              contents of entries TAP0_IDX and TAP1_IDX
//   ready               high when writes are accepted and reads are valid
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned ZERO_REG = DEF_ZERO_REG,
    parameter int unsigned BYPASS   = DEF_BYPASS,
    parameter int unsigned TAP0_IDX = DEF_TAP0_IDX,
    parameter int unsigned TAP1_IDX = DEF_TAP1_IDX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] Din,
    input  logic              we,
    input  logic              clearReq,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic [DATA_W-1:0] v0,
    output logic [DATA_W-1:0] a0,
    output logic              ready
);

    localparam int unsigned       DEPTH  = 1 << ADDR_W;
    localparam logic              ZR     = (ZERO_REG != 0);
    localparam logic              BYP    = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] TAP0_A = ADDR_W'(TAP0_IDX);
    localparam logic [ADDR_W-1:0] TAP1_A = ADDR_W'(TAP1_IDX);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              clrEn;
    logic [ADDR_W-1:0] clrAddr;
    logic              wrEn;

    regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clearReq (clearReq),
        .ready    (ready),
        .clrEn    (clrEn),
        .clrAddr  (clrAddr)
    );

    // A coincident clearReq wins over the write; entry 0 is read-only under ZERO_REG.
    assign wrEn = ready && we && !clearReq && !(ZR && (writeReg == '0));

    // No reset on the array: zeroing is done only by the sweep.
    // clrEn and wrEn are mutually exclusive (clrEn only in CLEAR, wrEn only in IDLE).
    always_ff @(posedge clk) begin
        if (clrEn) begin
            mem_q[clrAddr] <= '0;
        end else if (wrEn) begin
            mem_q[writeReg] <= Din;
        end
    end

    function automatic logic [DATA_W-1:0] rd_val(
        input logic [ADDR_W-1:0] idx,
        input logic [DATA_W-1:0] stored,
        input logic              wr,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        if (ZR && (idx == '0)) begin
            return '0;
        end
        if (BYP && wr && (idx == waddr)) begin
            return wdata;
        end
        return stored;
    endfunction

    always_comb begin
        reg1 = '0;
        reg2 = '0;
        if (ready) begin
            reg1 = rd_val(readReg1, mem_q[readReg1], wrEn, writeReg, Din);
            reg2 = rd_val(readReg2, mem_q[readReg2], wrEn, writeReg, Din);
        end
        v0 = rd_val(TAP0_A, mem_q[TAP0_A], wrEn, writeReg, Din);
        a0 = rd_val(TAP1_A, mem_q[TAP1_A], wrEn, writeReg, Din);
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  readReg1, readReg2, writeReg;
    logic [31:0] Din;
    logic        we, clearReq;

    logic [31:0] reg1, reg2, v0, a0;
    logic        ready;
    logic [31:0] reg1_nb, reg2_nb, v0_nb, a0_nb;
    logic        ready_nb;

    logic        rst_s;
    logic [2:0]  readReg1_s, readReg2_s, writeReg_s;
    logic [15:0] Din_s;
    logic        we_s, clearReq_s;
    logic [15:0] reg1_s, reg2_s, v0_s, a0_s;
    logic        ready_s;

    int errors = 0;
    int checks = 0;
    int n_main, n_small;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .rst(rst), .readReg1(readReg1), .readReg2(readReg2),
        .writeReg(writeReg), .Din(Din), .we(we), .clearReq(clearReq),
        .reg1(reg1), .reg2(reg2), .v0(v0), .a0(a0), .ready(ready)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .readReg1(readReg1), .readReg2(readReg2),
        .writeReg(writeReg), .Din(Din), .we(we), .clearReq(clearReq),
        .reg1(reg1_nb), .reg2(reg2_nb), .v0(v0_nb), .a0(a0_nb), .ready(ready_nb)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3)) dut_s (
        .clk(clk), .rst(rst_s), .readReg1(readReg1_s), .readReg2(readReg2_s),
        .writeReg(writeReg_s), .Din(Din_s), .we(we_s), .clearReq(clearReq_s),
        .reg1(reg1_s), .reg2(reg2_s), .v0(v0_s), .a0(a0_s), .ready(ready_s)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rst_s = 1'b1;
        readReg1 = '0; readReg2 = '0; writeReg = '0; Din = '0; we = 1'b0; clearReq = 1'b0;
        readReg1_s = '0; readReg2_s = '0; writeReg_s = '0; Din_s = '0; we_s = 1'b0; clearReq_s = 1'b0;

        // Reset state
        tick; tick;
        chk("rst_ready", ready, 0);
        chk("rst_reg1", reg1, 0);
        rst = 1'b0;

        // Initial sweep: ready after exactly 32 edges
        n_main = 0;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (ready && n_main == 0) begin
                n_main = i;
                break;
            end
        end
        chk("sweep_len", n_main, 32);
        chk("sweep_ready_nb", ready_nb, 1);

        for (int i = 0; i < 32; i++) begin
            readReg1 = 5'(i);
            readReg2 = 5'(31 - i);
            #1;
            chk($sformatf("zero_r1_%0d", i), reg1, 0);
            chk($sformatf("zero_r2_%0d", i), reg2, 0);
        end

        // Write/read through ports and taps
        we = 1'b1; writeReg = 5'd2; Din = 32'hDEADBEEF;
        tick;
        writeReg = 5'd4; Din = 32'h12345678;
        tick;
        we = 1'b0; readReg1 = 5'd2; readReg2 = 5'd4;
        #1;
        chk("wr_v0", v0, 32'hDEADBEEF);
        chk("wr_a0", a0, 32'h12345678);
        chk("wr_reg1", reg1, 32'hDEADBEEF);
        chk("wr_reg2", reg2, 32'h12345678);

        // Both ports on one entry
        readReg1 = 5'd4; readReg2 = 5'd4;
        #1;
        chk("dual_reg1", reg1, 32'h12345678);
        chk("dual_reg2", reg2, 32'h12345678);

        // Bypass on read port
        we = 1'b1; writeReg = 5'd7; Din = 32'hA5A5A5A5; readReg1 = 5'd7;
        #1;
        chk("byp_reg1", reg1, 32'hA5A5A5A5);
        chk("nobyp_reg1_old", reg1_nb, 0);
        tick;
        we = 1'b0;
        #1;
        chk("nobyp_reg1_new", reg1_nb, 32'hA5A5A5A5);

        // Bypass on tap
        we = 1'b1; writeReg = 5'd2; Din = 32'h11111111;
        #1;
        chk("byp_v0", v0, 32'h11111111);
        chk("nobyp_v0_old", v0_nb, 32'hDEADBEEF);
        tick;
        we = 1'b0;
        #1;
        chk("nobyp_v0_new", v0_nb, 32'h11111111);

        // Zero register
        we = 1'b1; writeReg = 5'd0; Din = 32'hFFFFFFFF; readReg1 = 5'd0;
        #1;
        chk("zr_before", reg1, 0);
        tick;
        we = 1'b0;
        #1;
        chk("zr_after", reg1, 0);
        chk("zr_after_nb", reg1_nb, 0);

        // Clear priority over a coincident write
        readReg1 = 5'd4; readReg2 = 5'd5;
        we = 1'b1; writeReg = 5'd5; Din = 32'h55555555; clearReq = 1'b1;
        #1;
        chk("clr_ready_pre", ready, 1);
        tick;
        we = 1'b0; clearReq = 1'b0;
        #1;
        chk("clr_ready_post", ready, 0);
        chk("clr_reg1_forced", reg1, 0);
        chk("clr_a0_unforced", a0, 32'h12345678);
        // clearReq during the sweep is ignored; a write during the sweep is dropped
        n_main = 0;
        for (int i = 1; i <= 40; i++) begin
            tick;
            clearReq = (i == 5);
            we = (i == 10);
            writeReg = 5'd1; Din = 32'hCAFEF00D;
            if (ready && n_main == 0) begin
                n_main = i;
                break;
            end
        end
        clearReq = 1'b0; we = 1'b0;
        chk("clr_sweep_len", n_main, 32);
        readReg1 = 5'd5; readReg2 = 5'd1;
        #1;
        chk("clr_e5", reg1, 0);
        chk("clr_e1_drop", reg2, 0);
        chk("clr_v0", v0, 0);

        // Reset mid-sweep (main) and mid-operation (small)
        rst = 1'b1; rst_s = 1'b1;
        tick;
        rst = 1'b0; rst_s = 1'b0;
        for (int i = 1; i <= 10; i++) tick;
        chk("mid_ready_main", ready, 0);
        chk("mid_ready_small", ready_s, 1);
        rst = 1'b1; rst_s = 1'b1;
        #1;
        chk("async_rst_small", ready_s, 0);
        tick;
        rst = 1'b0; rst_s = 1'b0;
        n_main = 0; n_small = 0;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (ready && n_main == 0) n_main = i;
            if (ready_s && n_small == 0) n_small = i;
            if (n_main != 0 && n_small != 0) break;
        end
        chk("restart_len_main", n_main, 32);
        chk("restart_len_small", n_small, 8);

        // Small configuration function
        readReg1_s = 3'd3;
        #1;
        chk("s_zero", reg1_s, 0);
        we_s = 1'b1; writeReg_s = 3'd4; Din_s = 16'hBEEF;
        tick;
        writeReg_s = 3'd0; Din_s = 16'hFFFF; readReg1_s = 3'd0;
        tick;
        we_s = 1'b0; readReg2_s = 3'd4;
        #1;
        chk("s_a0", a0_s, 16'hBEEF);
        chk("s_reg2", reg2_s, 16'hBEEF);
        chk("s_zr", reg1_s, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, entry 0 reads as zero and ignores writes.
REQ-004 SHALL have parameter BYPASS, default 1; when 1, a same-cycle write is forwarded to the read ports.
REQ-005 SHALL have parameters TAP0_IDX, default 2, and TAP1_IDX, default 4, the indices of the debug taps.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port readReg1, input, ADDR_W, read port 1 index.
REQ-009 SHALL have port readReg2, input, ADDR_W, read port 2 index.
REQ-010 SHALL have port writeReg, input, ADDR_W, write index.
REQ-011 SHALL have port Din, input, DATA_W, write data.
REQ-012 SHALL have port we, input, 1, write enable.
REQ-013 SHALL have port clearReq, input, 1, one-cycle pulse requesting a full clear.
REQ-014 SHALL have port reg1, output, DATA_W, read port 1 data.
REQ-015 SHALL have port reg2, output, DATA_W, read port 2 data.
REQ-016 SHALL have port v0, output, DATA_W, content of entry TAP0_IDX.
REQ-017 SHALL have port a0, output, DATA_W, content of entry TAP1_IDX.
REQ-018 SHALL have port ready, output, 1, high when the file accepts writes and returns valid reads.

Function
REQ-019 SHALL implement a two-state FSM, CLEAR and IDLE, with an ADDR_W-bit sweep counter clrCnt.
REQ-020 SHALL, in CLEAR, write zero to entry clrCnt on each rising clk edge and increment clrCnt.
REQ-021 SHALL go CLEAR->IDLE on the edge that clears entry DEPTH-1, so a sweep takes exactly DEPTH cycles.
REQ-022 SHALL go IDLE->CLEAR with clrCnt=0 on the edge where clearReq=1.
REQ-023 SHALL drive ready=1 only in IDLE.
REQ-024 SHALL, in IDLE with we=1, write Din to entry writeReg on the rising clk edge; writes in CLEAR are dropped.
REQ-025 SHALL give clearReq priority over a coincident we: the write is dropped and the sweep starts.
REQ-026 SHALL drop writes to entry 0 when ZERO_REG=1.
REQ-027 SHALL drive reg1, reg2, v0 and a0 combinationally from the storage array, with no read latency.
REQ-028 SHALL force reg1 and reg2 to zero while ready=0, and force any port addressing entry 0 to zero when ZERO_REG=1.
REQ-029 SHALL, with BYPASS=1, ready=1, we=1 and readRegN==writeReg (and not entry 0 under ZERO_REG), drive regN=Din in the same cycle; with BYPASS=0, regN shows the old value until the edge.
REQ-030 SHALL apply the bypass rule of REQ-029 to v0 and a0 as well.
REQ-031 SHALL let both read ports address the same entry at once without conflict.
REQ-032 SHALL ignore clearReq while already in CLEAR; the sweep is not restarted.

Reset
REQ-033 SHALL, while rst=1, asynchronously hold the FSM in CLEAR with clrCnt=0 and ready=0.
REQ-034 SHALL start the sweep on the first rising edge after rst falls; ready rises DEPTH cycles later.
REQ-035 SHALL let rst asserted mid-sweep or mid-operation restart the sweep from entry 0.
REQ-036 SHALL NOT reset the storage array asynchronously; zeroing is done only by the sweep.

Structure
REQ-037 SHALL place the state encoding (CLEAR, IDLE) and the default parameter values in shared package regfile_pkg.
REQ-038 SHALL implement the FSM and clrCnt as sub-module regfile_clr_seq, which outputs ready, clrEn and clrAddr.
REQ-039 SHALL keep the storage array, the write mux and the bypass logic in regfile_mp.

Verification
REQ-040 SHALL cover reset: pulse rst, defaults -> ready=0 for 32 cycles, then ready=1, and all 32 entries read 0x00000000.
REQ-041 SHALL cover write/read: write 0xDEADBEEF to entry 2 and 0x12345678 to entry 4 -> v0=0xDEADBEEF and a0=0x12345678 after the edges; reg1 and reg2 at indices 2 and 4 match.
REQ-042 SHALL cover bypass: we=1, writeReg=7, Din=0xA5A5A5A5, readReg1=7 in the same cycle -> reg1=0xA5A5A5A5 before the edge; with BYPASS=0, reg1 keeps the old value until the edge.
REQ-043 SHALL cover the zero register: write 0xFFFFFFFF to entry 0 -> reg1=0 at readReg1=0, before and after the edge.
REQ-044 SHALL cover clear priority: clearReq=1 and we=1 to entry 5 in the same cycle -> write dropped, ready=0 for 32 cycles, entry 5 reads 0.
REQ-045 SHALL cover reset mid-sweep: assert rst at sweep cycle 10 -> sweep restarts at entry 0 and ready rises 32 cycles after rst falls; repeat with DATA_W=16, ADDR_W=3, where ready rises after 8 cycles.
